// File: rtl/bag_mac_if.sv
// Stream and result bundle between a feature source, the MAC accumulator and the voting stage.
// Valid/ready: a beat or result moves on a rising edge where valid and ready are both high; the
// sender keeps valid and payload steady until that edge; ready may depend on state, never on valid.
interface bag_mac_if;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_feat;
  logic [1:0]  in_wt;
  logic        sum_valid;
  logic        sum_ready;
  logic [15:0] sum_out;
  logic        vote;

  modport master (
    output in_valid, in_feat, in_wt, sum_ready,
    input  in_ready, sum_valid, sum_out, vote
  );

  modport slave (
    input  in_valid, in_feat, in_wt, sum_ready,
    output in_ready, sum_valid, sum_out, vote
  );
endinterface

// File: rtl/bag_mac_accumulator.sv
// Sequential signed multiply-accumulate over N_FEAT beats for one bagging learner,
// presenting a wrapped 16-bit sum and a thresholded vote through a valid/ready handshake.
module bag_mac_accumulator #(
  parameter int                 N_FEAT = 16,
  parameter logic signed [15:0] THRESH = 16'sd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  bag_mac_if.slave   bus,
  output logic       busy,
  output logic [7:0] beat_cnt,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(N_FEAT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [15:0]        acc;
  logic [15:0]        acc_nxt;
  logic [15:0]        sum_q;
  logic               vote_q;
  logic signed [10:0] prod;
  logic               xfer;
  logic               last_beat;

  // 11-bit signed product covers -510..+512 exactly, including -256 * -2.
  always_comb begin
    prod    = $signed({{2{bus.in_feat[8]}}, bus.in_feat}) * $signed({{9{bus.in_wt[1]}}, bus.in_wt});
    acc_nxt = acc + {{5{prod[10]}}, prod};
  end

  assign xfer      = (state == ACC) && bus.in_valid;
  assign last_beat = (beat_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = ACC;
      ACC:  if (xfer && last_beat) state_nxt = DONE;
      DONE: if (bus.sum_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.sum_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      ACC: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
      end
      DONE: begin
        bus.sum_valid = 1'b1;
        busy          = 1'b1;
      end
      default: ;
    endcase
  end

  // Result registers load only on the final beat so they hold after the handshake
  // and through the next inference until its own final beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      beat_cnt <= '0;
      sum_q    <= '0;
      vote_q   <= 1'b0;
    end else if (state == IDLE && start) begin
      acc      <= '0;
      beat_cnt <= '0;
    end else if (xfer) begin
      acc      <= acc_nxt;
      beat_cnt <= beat_cnt + 8'd1;
      if (last_beat) begin
        sum_q  <= acc_nxt;
        vote_q <= ($signed(acc_nxt) > THRESH);
      end
    end
  end

  assign bus.sum_out = sum_q;
  assign bus.vote    = vote_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_bag_mac_accumulator.sv
// Randomized bench for bag_mac_accumulator: two N_FEAT=4 instances (THRESH 0 and -87) share
// one stimulus stream, a third N_FEAT=64 instance covers long runs and modulo wrap.
module tb_bag_mac_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       tb_start;
  logic       tb_valid;
  logic       tb_sready;
  logic       sel_b;
  logic [8:0] tb_feat;
  logic [1:0] tb_wt;

  logic       start_a, start_b;
  logic       busy_a, busy_n, busy_b;
  logic [7:0] cnt_a, cnt_n, cnt_b;
  logic [1:0] fsm_a, fsm_n, fsm_b;

  bag_mac_if ifa ();
  bag_mac_if ifn ();
  bag_mac_if ifb ();

  assign start_a       = tb_start & ~sel_b;
  assign start_b       = tb_start & sel_b;
  assign ifa.in_valid  = tb_valid & ~sel_b;
  assign ifn.in_valid  = tb_valid & ~sel_b;
  assign ifb.in_valid  = tb_valid & sel_b;
  assign ifa.in_feat   = tb_feat;
  assign ifn.in_feat   = tb_feat;
  assign ifb.in_feat   = tb_feat;
  assign ifa.in_wt     = tb_wt;
  assign ifn.in_wt     = tb_wt;
  assign ifb.in_wt     = tb_wt;
  assign ifa.sum_ready = tb_sready & ~sel_b;
  assign ifn.sum_ready = tb_sready & ~sel_b;
  assign ifb.sum_ready = tb_sready & sel_b;

  bag_mac_accumulator #(.N_FEAT(4), .THRESH(16'sd0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(ifa.slave),
    .busy(busy_a), .beat_cnt(cnt_a), .fsm_state(fsm_a)
  );

  bag_mac_accumulator #(.N_FEAT(4), .THRESH(-16'sd87)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(ifn.slave),
    .busy(busy_n), .beat_cnt(cnt_n), .fsm_state(fsm_n)
  );

  bag_mac_accumulator #(.N_FEAT(64), .THRESH(16'sd0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(ifb.slave),
    .busy(busy_b), .beat_cnt(cnt_b), .fsm_state(fsm_b)
  );

  logic        obs_valid, obs_rdy, obs_vote, obs_busy;
  logic [15:0] obs_sum;
  logic [7:0]  obs_cnt;
  assign obs_valid = sel_b ? ifb.sum_valid : ifa.sum_valid;
  assign obs_rdy   = sel_b ? ifb.in_ready  : ifa.in_ready;
  assign obs_vote  = sel_b ? ifb.vote      : ifa.vote;
  assign obs_sum   = sel_b ? ifb.sum_out   : ifa.sum_out;
  assign obs_busy  = sel_b ? busy_b        : busy_a;
  assign obs_cnt   = sel_b ? cnt_b         : cnt_a;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          feat_v[64];
  int          wt_v[64];
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer dot product truncated to 16 bits; votes are signed compares.
  task automatic run_inf(input int n, input bit gaps, input int hold, input bit early);
    int          s;
    logic [15:0] e;
    logic        ev, evn;
    s = 0;
    for (int i = 0; i < n; i++) s += feat_v[i] * wt_v[i];
    exp_q.push_back(16'(s));
    @(negedge clk);
    tb_start = 1'b1;
    if (early) begin
      tb_valid = 1'b1;
      tb_feat  = 9'd77;
      tb_wt    = 2'b01;
    end
    @(negedge clk);
    tb_start = 1'b0;
    tb_valid = 1'b0;
    check("start_busy", obs_busy, 1);
    check("start_cnt", obs_cnt, 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          tb_valid = 1'b0;
          @(negedge clk);
        end
      end
      check("beat_rdy", obs_rdy, 1);
      tb_valid = 1'b1;
      tb_feat  = 9'(feat_v[i]);
      tb_wt    = 2'(wt_v[i]);
      @(negedge clk);
    end
    tb_valid = 1'b0;
    e   = exp_q.pop_front();
    ev  = ($signed(e) > 0);
    evn = ($signed(e) > -87);
    check("done_valid", obs_valid, 1);
    check("done_sum", obs_sum, e);
    check("done_vote", obs_vote, ev);
    check("done_cnt", obs_cnt, n);
    check("done_rdy", obs_rdy, 0);
    if (!sel_b) check("done_vote_n", ifn.vote, evn);
    repeat (hold) begin
      tb_start  = 1'($urandom_range(0, 1));
      tb_sready = 1'b0;
      @(negedge clk);
      check("hold_valid", obs_valid, 1);
      check("hold_sum", obs_sum, e);
      check("hold_vote", obs_vote, ev);
      check("hold_rdy", obs_rdy, 0);
    end
    tb_sready = 1'b1;
    tb_start  = 1'b1;
    @(negedge clk);
    tb_sready = 1'b0;
    tb_start  = 1'b0;
    check("post_valid", obs_valid, 0);
    check("post_busy", obs_busy, 0);
    check("post_sum", obs_sum, e);
    check("post_vote", obs_vote, ev);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      feat_v[i] = int'($urandom_range(0, 511)) - 256;
      wt_v[i]   = int'($urandom_range(0, 3)) - 2;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    sel_b     = 1'b0;
    tb_start  = 1'b1;
    tb_valid  = 1'b1;
    tb_sready = 1'b1;
    tb_feat   = 9'd5;
    tb_wt     = 2'b01;
    repeat (3) @(negedge clk);
    check("rst_valid", obs_valid, 0);
    check("rst_rdy", obs_rdy, 0);
    check("rst_sum", obs_sum, 0);
    check("rst_vote", obs_vote, 0);
    check("rst_busy", obs_busy, 0);
    check("rst_cnt", obs_cnt, 0);
    sel_b = 1'b1;
    #1;
    check("rst_b_busy", obs_busy, 0);
    check("rst_b_valid", obs_valid, 0);
    sel_b     = 1'b0;
    tb_start  = 1'b0;
    tb_valid  = 1'b0;
    tb_sready = 1'b0;
    rst_n     = 1'b1;

    feat_v[0:3] = '{10, 20, 30, 40};
    wt_v[0:3]   = '{1, 1, 1, 1};
    run_inf(4, 1'b0, 0, 1'b0);

    feat_v[0:3] = '{-5, 7, -100, 3};
    wt_v[0:3]   = '{-2, 1, 1, -1};
    run_inf(4, 1'b0, 1, 1'b0);

    feat_v[0:3] = '{123, -200, 255, -256};
    wt_v[0:3]   = '{0, 0, 0, 0};
    run_inf(4, 1'b1, 2, 1'b0);

    feat_v[0:3] = '{-256, -256, 3, 9};
    wt_v[0:3]   = '{-2, -2, 1, -1};
    run_inf(4, 1'b1, 5, 1'b1);

    // Abort after two beats: reset must discard the partial sum and clear the result.
    @(negedge clk);
    tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    tb_valid = 1'b1;
    tb_feat  = 9'd50;
    tb_wt    = 2'b01;
    repeat (2) @(negedge clk);
    check("mid_cnt", obs_cnt, 2);
    rst_n     = 1'b0;
    tb_start  = 1'b1;
    tb_sready = 1'b1;
    @(negedge clk);
    check("mid_busy", obs_busy, 0);
    check("mid_valid", obs_valid, 0);
    check("mid_cnt0", obs_cnt, 0);
    check("mid_sum0", obs_sum, 0);
    check("mid_rdy", obs_rdy, 0);
    rst_n     = 1'b1;
    tb_start  = 1'b0;
    tb_valid  = 1'b0;
    tb_sready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      feat_v[i] = 1;
      wt_v[i]   = 1;
    end
    run_inf(4, 1'b0, 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      fill_rand(4);
      run_inf(4, 1'b1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    sel_b = 1'b1;
    for (int i = 0; i < 64; i++) begin
      feat_v[i] = -256;
      wt_v[i]   = -2;
    end
    run_inf(64, 1'b0, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      fill_rand(64);
      run_inf(64, 1'b1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    sel_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bag_mac_accumulator.md
Name: bag_mac_accumulator

Overview:
- Sequential multiply-accumulate front end for one bagging base learner.
- Consumes a stream of signed 9-bit features, each paired with a signed 2-bit weight.
- Each accepted beat updates a 16-bit running sum: acc + feature*weight, with the same arithmetic as the downstream csa add/multiply datapath.
- After N_FEAT beats it presents the sum and a thresholded vote to the ensemble voting stage through a valid/ready handshake.

Parameters:
- N_FEAT, 16: beats per inference; legal range 1..255.
- THRESH, 0: signed 16-bit threshold. vote = 1 when the signed sum is strictly greater than THRESH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that begins an inference; honoured only in IDLE.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  block can accept a beat.
- in_feat  in  9  signed feature.
- in_wt  in  2  signed weight (-2..1).
- sum_valid  out  1  result valid.
- sum_ready  in  1  downstream accepts the result.
- sum_out  out  16  signed accumulated sum.
- vote  out  1  class vote, defined as sum_out > THRESH (signed compare).
- busy  out  1  high in ACC or DONE.
- beat_cnt  out  8  beats accepted in the current inference.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE; acc=0, beat_cnt=0.
  - Outputs: in_ready=0, sum_valid=0, sum_out=0, vote=0, busy=0.
  - Reset mid-operation discards the partial sum. No result is emitted.
- State IDLE:
  - in_ready=0.
  - start=1 → acc<=0, beat_cnt<=0, go to ACC.
  - in_valid is ignored.
- State ACC:
  - in_ready=1.
  - A transfer occurs when in_valid & in_ready: acc <= acc + sext16(in_feat*in_wt).
  - Product is signed 11-bit, range -510..512, sign-extended to 16 bits.
  - Sum wraps modulo 2^16 with no saturation, matching the downstream adder.
  - beat_cnt increments on each transfer.
  - The transfer with beat_cnt==N_FEAT-1 moves the state to DONE.
  - Cycles with in_valid=0 hold all state; gaps are unlimited.
  - start is ignored.
- State DONE:
  - sum_valid=1; sum_out=acc; vote registered alongside acc.
  - in_ready=0.
  - sum_out and vote stay stable while sum_valid=1 and sum_ready=0.
  - sum_valid & sum_ready → IDLE on the next edge. sum_valid drops; sum_out and vote hold their last values.
  - start is ignored, including when it coincides with the handshake cycle. A new inference needs start in IDLE.
- Latency:
  - sum_valid rises on the edge that accepts the last beat, so it is visible the cycle after the last beat is presented.
  - Minimum inference: 1 (start) + N_FEAT + 1 (handshake) cycles.
  - Throughput is one beat per cycle in ACC.
- Boundary rules:
  - N_FEAT=1: the first beat goes directly to DONE.
  - in_wt=2'b10 (-2) and in_feat=-256 give +512. This is the maximum product and must be handled exactly.
  - in_wt=0 adds zero but still counts as a beat.
  - rst_n=0 overrides start, in_valid and sum_ready in the same cycle.
- busy is high in ACC and DONE.

Test Plan:
- N_FEAT=4, THRESH=0; start, then feats 10,20,30,40 with wt=1 back-to-back → sum_valid one cycle after the last beat; sum_out=100, vote=1, beat_cnt=4.
- N_FEAT=4; feats -5,7,-100,3 with wts -2,1,1,-1 → sum_out=10+7-100-3=-86 (0xFFAA), vote=0; a second run with THRESH=-87 gives vote=1.
- N_FEAT=64; feat=-256, wt=-2 every beat → 64*512=32768 wraps to sum_out=0x8000 (-32768), vote=0. This proves modulo wrap with no saturation.
- Backpressure and gaps: in_valid toggling 1,0,0,1,... over 4 beats; hold sum_ready=0 for 5 cycles → sum_out and vote stable, in_ready=0, start pulses ignored; sum_ready=1 → IDLE next cycle.
- Reset mid-operation: assert rst_n=0 after 2 of 4 beats → next cycle in IDLE, acc=0, sum_valid=0. A fresh start with 4×(feat=1, wt=1) yields sum_out=4.
- Start in IDLE while in_valid=1: no beat is accepted in the start cycle. The first accepted beat is the one in the following cycle.
